fir_polyphase_sched: RTL and testbench

Scheduler for the 6-phase polyphase FIR datapath. It accepts a serial sample stream, buffers one frame of 6 samples plus 3 samples of history, and time-multiplexes one shared 4-tap multiply-add across the 6 output phases, one phase per cycle. Per-phase coefficient sets live in a writable register file. The block replaces six parallel per-phase output units with a single sequenced datapath and emits results on a valid/ready output stream tagged with the phase index.

---
 rtl/fir_polyphase_sched.sv | 191 +++++++++++++++++++
 tb/tb_fir_polyphase_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_polyphase_sched.sv
// fir_polyphase_sched
// Collects a 6-sample frame plus 3 samples of history, then walks one shared
// 4-tap multiply-add across the 6 output phases, one phase per cycle, and
// presents each result on a valid/ready stream tagged with its phase index.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | in_ready=1, accepting samples into x[cnt], cnt 0..5
// RUN   | in_ready=0, issuing phases 0..5 whenever the output slot is free

module fir_polyphase_sched #(
    parameter int W_IN  = 7,
    parameter int C_IN  = 5,
    parameter int Y_OUT = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             coef_we,
    input  logic [4:0]       coef_addr,
    input  logic [C_IN-1:0]  coef_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_OUT-1:0] out_data,
    output logic [2:0]       out_phase
);

    localparam int PW = W_IN + C_IN;   // full-precision product width
    localparam int SW = PW + 2;        // accumulation width for 4 taps

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_issue;

    logic [2:0]        r_cnt;
    logic [2:0]        r_phase;
    logic [W_IN-1:0]   r_x [0:5];
    logic [W_IN-1:0]   r_h [0:2];
    logic [C_IN-1:0]   r_coef [0:31];   // entries 24..31 are never written

    logic              r_out_valid;
    logic [Y_OUT-1:0]  r_out_data;
    logic [2:0]        r_out_phase;

    logic [W_IN-1:0]   w_win [0:15];    // w[-3..5] mapped to indices 0..8
    logic [4:0]        w_cidx [0:3];
    logic [3:0]        w_widx [0:3];
    logic [PW-1:0]     w_prod [0:3];
    logic [SW-1:0]     w_sum;
    logic [Y_OUT-1:0]  w_y;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_phase = r_out_phase;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and issue decode; clr overrides everything
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_ready = 1'b1;
                w_accept = in_valid && !clr;
                if (w_accept && (r_cnt == 3'd5)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = (!r_out_valid || out_ready) && !clr;
                if (w_issue && (r_phase == 3'd5)) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
        if (clr) begin
            w_state_nxt = ST_FILL;
        end
    end

    // Sample window and shared 4-tap multiply-add for the current phase
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_win[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            w_win[i] = r_h[i];
        end
        for (int i = 0; i < 6; i++) begin
            w_win[i+3] = r_x[i];
        end
        w_sum = '0;
        for (int t = 0; t < 4; t++) begin
            w_cidx[t] = {r_phase, 2'(t)};
            w_widx[t] = {1'b0, r_phase} + 4'd3 - 4'(t);
            // Operands sign-extended to the product width so the low PW bits
            // of the unsigned multiply are the exact signed product.
            w_prod[t] = {{W_IN{r_coef[w_cidx[t]][C_IN-1]}}, r_coef[w_cidx[t]]}
                      * {{C_IN{w_win[w_widx[t]][W_IN-1]}}, w_win[w_widx[t]]};
            w_sum     = w_sum + {{2{w_prod[t][PW-1]}}, w_prod[t]};
        end
        w_y = Y_OUT'($signed(w_sum));
    end

    // Frame capture, history update, phase sequencing and output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_phase <= '0;
            for (int i = 0; i < 6; i++) begin
                r_x[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_h[i] <= '0;
            end
        end else if (clr) begin
            r_cnt       <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_h[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 6; i++) begin
                    if (r_cnt == 3'(i)) begin
                        r_x[i] <= in_data;
                    end
                end
                r_cnt <= (r_cnt == 3'd5) ? 3'd0 : r_cnt + 3'd1;
            end
            if (w_issue) begin
                r_out_data  <= w_y;
                r_out_phase <= r_phase;
                r_out_valid <= 1'b1;
                if (r_phase == 3'd5) begin
                    r_phase <= 3'd0;
                    r_cnt   <= 3'd0;
                    r_h[0]  <= r_x[3];
                    r_h[1]  <= r_x[4];
                    r_h[2]  <= r_x[5];
                end else begin
                    r_phase <= r_phase + 3'd1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Coefficient file; a read in the write cycle sees the previous value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < 24; i++) begin
                if (coef_addr == 5'(i)) begin
                    r_coef[i] <= coef_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_polyphase_sched.sv
// Bench for fir_polyphase_sched: directed frames plus randomized frames with
// random backpressure, checked against a frame-level arithmetic model.

module tb_fir_polyphase_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [4:0]  coef_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;
    logic [2:0]  out_phase;

    fir_polyphase_sched #(.W_IN(7), .C_IN(5), .Y_OUT(20)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_phase  (out_phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int coef_m [24];
    int h_m [3];
    int fx [6];
    int ey [6];
    int cap_v [6];
    int cap_p [6];
    int cap_d [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 24; i++) coef_m[i] = 0;
        for (int i = 0; i < 3; i++) h_m[i] = 0;
    endtask

    // Expected outputs of one frame from y_p = sum coef[p*4+t]*w[p-t]
    task automatic model_frame();
        for (int p = 0; p < 6; p++) begin
            int s;
            s = 0;
            for (int t = 0; t < 4; t++) begin
                int k;
                int w;
                k = p - t;
                w = (k < 0) ? h_m[k+3] : fx[k];
                s += coef_m[p*4+t] * w;
            end
            ey[p] = s;
        end
        for (int i = 0; i < 3; i++) h_m[i] = fx[3+i];
    endtask

    task automatic apply_reset();
        clr = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rstn = 1'b0;
        #7;
        rstn = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1'b1;
        coef_addr = 5'(a);
        coef_wdata = 5'(v);
        tick();
        coef_we = 1'b0;
        if (a < 24) coef_m[a] = v;
    endtask

    task automatic set_all_coefs(input int v);
        for (int a = 0; a < 24; a++) write_coef(a, v);
    endtask

    task automatic set_ramp(input int first);
        for (int i = 0; i < 6; i++) fx[i] = first + i;
    endtask

    // Drives fx[0..n-1]; returns one step after the edge that took the last one
    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            while (!in_ready && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
            end
            in_valid = 1'b1;
            in_data = 7'(fx[i]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect6();
        out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            tick();
            coef_we = 1'b0;
            cap_v[p] = int'(out_valid);
            cap_p[p] = int'(out_phase);
            cap_d[p] = $signed(out_data);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
        checks++;
        if (out_data !== 20'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++;
        if (out_phase !== 3'd0) begin errors++; $display("FAIL reset_out_phase: got %0d want 0", out_phase); end
    endtask

    task automatic test_ones();
        apply_reset();
        set_all_coefs(1);
        for (int f = 0; f < 2; f++) begin
            set_ramp(1 + 6*f);
            model_frame();
            send_samples(6);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid f%0d: got %0d want 0", f, out_valid); end
            collect6();
            for (int p = 0; p < 6; p++) begin
                checks++;
                if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                    errors++;
                    $display("FAIL ones f%0d p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                             f, p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL ones_in_ready_after f%0d: got %0d want 1", f, in_ready); end
        end
    endtask

    task automatic test_phase3();
        apply_reset();
        write_coef(12, 2);
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                errors++;
                $display("FAIL phase3 p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
            end
        end
    endtask

    task automatic test_extreme();
        apply_reset();
        set_all_coefs(-16);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 6; i++) fx[i] = -64;
            model_frame();
            send_samples(6);
            collect6();
            for (int p = 0; p < 6; p++) begin
                checks++;
                if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                    errors++;
                    $display("FAIL extreme f%0d p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                             f, p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_all_coefs(1);
        set_ramp(1);
        model_frame();
        send_samples(6);
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_phase) !== p || $signed(out_data) !== ey[p]) begin
                errors++;
                $display("FAIL bp_pre p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, out_valid, out_phase, $signed(out_data), p, ey[p]);
            end
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_phase !== 3'd2 || $signed(out_data) !== ey[2] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c%0d: got v=%0d ph=%0d d=%0d rdy=%0d want 1/2/%0d/0",
                         c, out_valid, out_phase, $signed(out_data), in_ready, ey[2]);
            end
        end
        out_ready = 1'b1;
        for (int p = 3; p < 6; p++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_phase) !== p || $signed(out_data) !== ey[p]) begin
                errors++;
                $display("FAIL bp_post p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, out_valid, out_phase, $signed(out_data), p, ey[p]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_all_coefs(1);
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        set_ramp(7);
        model_frame();
        send_samples(6);
        tick(); tick(); tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 20'd0 || out_phase !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%0d d=%0d ph=%0d rdy=%0d want 0/0/0/1",
                     out_valid, out_data, out_phase, in_ready);
        end
        #2;
        rstn = 1'b1;
        tick();
        model_clear();
        set_all_coefs(1);
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                errors++;
                $display("FAIL after_reset p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
            end
        end
    endtask

    task automatic test_clr();
        apply_reset();
        set_all_coefs(1);
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        set_ramp(7);
        send_samples(4);
        // clr together with a valid sample: the sample must be dropped
        clr = 1'b1; in_valid = 1'b1; in_data = 7'd50;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) h_m[i] = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: got rdy=%0d v=%0d want 1/0", in_ready, out_valid);
        end
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                errors++;
                $display("FAIL clr_frame p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
            end
        end
        // clr while an output is stalled drops it
        set_ramp(20);
        send_samples(6);
        out_ready = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) h_m[i] = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_drop: got v=%0d rdy=%0d want 0/1", out_valid, in_ready);
        end
        set_ramp(1);
        model_frame();
        send_samples(6);
        collect6();
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                errors++;
                $display("FAIL clr_drop_frame p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                         p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
            end
        end
    endtask

    task automatic test_coef_same_cycle();
        apply_reset();
        set_all_coefs(1);
        for (int f = 0; f < 2; f++) begin
            set_ramp(1 + 6*f);
            model_frame();
            send_samples(6);
            if (f == 0) begin
                coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 5'd3;
            end
            collect6();
            if (f == 0) coef_m[0] = 3;
            for (int p = 0; p < 6; p++) begin
                checks++;
                if (cap_v[p] !== 1 || cap_p[p] !== p || cap_d[p] !== ey[p]) begin
                    errors++;
                    $display("FAIL coef_wr f%0d p%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                             f, p, cap_v[p], cap_p[p], cap_d[p], p, ey[p]);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            for (int a = 0; a < 24; a++) begin
                if (f == 0 || $urandom_range(0, 3) == 0)
                    write_coef(a, int'($urandom_range(0, 31)) - 16);
            end
            write_coef(24 + int'($urandom_range(0, 7)), int'($urandom_range(0, 31)) - 16);
            for (int i = 0; i < 6; i++) fx[i] = int'($urandom_range(0, 127)) - 64;
            model_frame();
            send_samples(6);
            begin
                int idx;
                int guard;
                bit held;
                int prev_d;
                int prev_p;
                idx = 0; guard = 0; held = 0; prev_d = 0; prev_p = 0;
                while (idx < 6 && guard < 300) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (held) begin
                        checks++;
                        if (out_valid !== 1'b1 || $signed(out_data) !== prev_d || int'(out_phase) !== prev_p) begin
                            errors++;
                            $display("FAIL rand_hold f%0d: got v=%0d ph=%0d d=%0d want 1/%0d/%0d",
                                     f, out_valid, out_phase, $signed(out_data), prev_p, prev_d);
                        end
                    end
                    if (out_valid && out_ready) begin
                        checks++;
                        if (int'(out_phase) !== idx || $signed(out_data) !== ey[idx]) begin
                            errors++;
                            $display("FAIL rand_out f%0d i%0d: got ph=%0d d=%0d want %0d/%0d",
                                     f, idx, out_phase, $signed(out_data), idx, ey[idx]);
                        end
                        idx++;
                    end
                    held = out_valid && !out_ready;
                    prev_d = $signed(out_data);
                    prev_p = int'(out_phase);
                    tick();
                    guard++;
                end
                checks++;
                if (idx !== 6) begin
                    errors++;
                    $display("FAIL rand_timeout f%0d: got %0d outputs want 6", f, idx);
                end
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_ones();
        test_phase3();
        test_extreme();
        test_backpressure();
        test_async_reset();
        test_clr();
        test_coef_same_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
